// File: rtl/riscv_pkg.sv
// Shared integer-register-file constants and address type, reused by decode,
// hazard and register-file logic.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_addr_t;

  // True when an address names a real architectural register (not x0).
  function automatic logic is_real_reg(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set on issue, cleared on
// writeback, wiped by flush. Register 0 is never marked pending.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    set,
  input  logic [AW-1:0]           setReg,
  input  logic                    clr,
  input  logic [AW-1:0]           clrReg,
  input  logic                    flush,
  input  logic [NRD-1:0][AW-1:0]  queryReg,
  output logic [NRD-1:0]          busy
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_next;

  // Clear is applied before set so a same-cycle issue wins; flush overrides both.
  always_comb begin
    w_pending_next = r_pending;
    if (clr && (clrReg != '0)) w_pending_next[clrReg] = 1'b0;
    if (set && (setReg != '0)) w_pending_next[setReg] = 1'b1;
    if (flush)                 w_pending_next = '0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_pending <= '0;
    else        r_pending <= w_pending_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_query
      assign busy[gi] = r_pending[queryReg[gi]];
    end
  endgenerate

endmodule

// File: rtl/banco_registros_sb.sv
// Integer register file with combinational reads, write-through bypass and a
// pending-producer scoreboard for hazard detection.
module banco_registros_sb
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [NRD-1:0][AW-1:0]  readReg,
  output logic [NRD-1:0][XLEN-1:0] readData,
  output logic [NRD-1:0]          readBusy,
  input  logic                    RegWrite,
  input  logic [AW-1:0]           writeReg,
  input  logic [XLEN-1:0]         writeData,
  input  logic                    issueValid,
  input  logic [AW-1:0]           issueReg,
  input  logic                    flush,
  output logic                    anyBusy
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_en;
  logic [NRD-1:0]  w_sb_busy;
  logic [NRD-1:0]  w_bypass;

  assign w_wr_en = RegWrite && (writeReg != '0);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[writeReg] <= writeData;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .set      (issueValid),
    .setReg   (issueReg),
    .clr      (RegWrite),
    .clrReg   (writeReg),
    .flush    (flush),
    .queryReg (readReg),
    .busy     (w_sb_busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_read
      assign w_bypass[gi] = w_wr_en && (readReg[gi] == writeReg);
      // x0 is masked explicitly so its storage is never observable.
      assign readData[gi] = w_bypass[gi]         ? writeData :
                            (readReg[gi] == '0)  ? '0        :
                                                   r_regs[readReg[gi]];
      // A same-cycle write already supplies the value, so the hazard is covered.
      assign readBusy[gi] = w_sb_busy[gi] & ~w_bypass[gi];
    end
  endgenerate

  assign anyBusy = |readBusy;

endmodule

// File: doc/banco_registros_sb.md
BANCO_REGISTROS_SB -- requirements
Module: banco_registros_sb

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32: data width in bits.
- NREGS, default 32: register count, power of two, minimum 2.
- NRD, default 2: number of read ports, 1 to 4.
- AW = log2(NREGS): derived address width.
REQ-002 Ports SHALL be, clock and reset first:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST_n  in  1  reset; asynchronous, active-low.
- readReg  in  NRD x AW  read addresses.
- readData  out  NRD x XLEN  read data.
- readBusy  out  NRD  per-port pending-producer flag.
- RegWrite  in  1  write enable.
- writeReg  in  AW  write address.
- writeData  in  XLEN  write data.
- issueValid  in  1  marks issueReg as having an in-flight producer.
- issueReg  in  AW  destination register being issued.
- flush  in  1  synchronous clear of all pending flags.
- anyBusy  out  1  OR of all readBusy bits.

Function
REQ-003 The block SHALL hold NREGS registers of XLEN bits each, plus one pending bit per register.
REQ-004 Register 0 SHALL always read as 0 and SHALL never be written or marked pending.
REQ-005 When RegWrite=1 and writeReg!=0, the block SHALL store writeData into register writeReg on the rising edge.
REQ-006 Reads SHALL be combinational: readData[i] = register[readReg[i]] in the same cycle.
REQ-007 Write-through bypass: when RegWrite=1, writeReg!=0 and readReg[i]==writeReg, readData[i] SHALL equal writeData in the same cycle.
REQ-008 When issueValid=1 and issueReg!=0, the block SHALL set pending[issueReg] on the next edge.
REQ-009 When RegWrite=1 and writeReg!=0, the block SHALL clear pending[writeReg] on the next edge.
REQ-010 If set and clear target the same register in the same cycle, set SHALL win and pending SHALL be 1 after the edge.
REQ-011 readBusy[i] SHALL equal pending[readReg[i]], forced to 0 when a same-cycle write to that register is in progress (bypass covers it).
REQ-012 When flush=1, all pending bits SHALL be 0 after the edge; flush SHALL take priority over issueValid; register contents SHALL be unaffected.
REQ-013 anyBusy SHALL be the combinational OR of readBusy[0..NRD-1].
REQ-014 Out-of-range addresses cannot occur because AW exactly spans NREGS; no saturation logic is required.

Reset
REQ-015 While RST_n=0, the block SHALL asynchronously force all registers to 0 and all pending bits to 0.
REQ-016 During reset, outputs SHALL read as follows: readData=0 except for the bypass path, readBusy=0, anyBusy=0.
REQ-017 The first write SHALL take effect on the first rising edge after RST_n deasserts.
REQ-018 Reset asserted mid-operation SHALL discard pending bits and register data with no partial-update residue.

Structure
REQ-019 XLEN, NREGS defaults, REG_AW and typedef reg_addr_t SHALL live in shared package riscv_pkg, reused by decode and hazard logic.
REQ-020 The pending-bit array SHALL be implemented in sub-module reg_scoreboard (ports: CLK, RST_n, set, setReg, clr, clrReg, flush, NRD query addresses, NRD busy outputs).
REQ-021 The data array and bypass muxes SHALL remain in the top module.

Verification
REQ-022 Write x5=0xDEADBEEF, then read x5 on port 0 in the next cycle: readData[0]=0xDEADBEEF.
REQ-023 Write x0=0x12345678: port 0 reading x0 returns 0 both in the same cycle and in the next cycle.
REQ-024 Same-cycle write x7=0xA5A5A5A5 with port 1 reading x7: readData[1]=0xA5A5A5A5 and readBusy[1]=0 in that cycle.
REQ-025 Issue x3, idle, then read x3: readBusy=1 and anyBusy=1. Write x3=0x1 while issuing x3 in the same cycle: busy remains 1. A further write of x3 clears busy.
REQ-026 Pend x1, x2 and x9, then flush=1 together with issueValid for x4: after the edge no register is pending and x9's data is unchanged.
REQ-027 Write x10=0xFF, pend x10, then pulse RST_n low asynchronously between edges: readData for x10 becomes 0 and readBusy becomes 0 immediately.
